// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types and constants for the cache-line memory adaptor
package cache_pkg;

    localparam int LINE_W      = 256;
    localparam int BEAT_W      = 64;
    localparam int ADDR_W      = 32;
    // Byte offset bits inside a 32-byte line; cleared to form the burst address.
    localparam int OFFSET_BITS = 5;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2,
        DONE     = 2'd3
    } adaptor_state_t;

endpackage

// File: rtl/cacheline_mem_adaptor.sv
// rtl/cacheline_mem_adaptor.sv - turns 256-bit cache line requests into 4-beat 64-bit memory bursts
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   pmem_read/_write    cache line request, held until pmem_resp
//   pmem_address        line address (low offset bits ignored)
//   pmem_wdata          line write data
//   pmem_resp           one-cycle completion pulse
//   pmem_rdata          assembled read line (registered)
//   burst_read/_write   memory burst request, decoded from state
//   burst_address       line-aligned burst address
//   burst_wdata         current write beat
//   burst_rdata         read beat from memory, valid with burst_resp
//   burst_resp          per-beat handshake from memory
module cacheline_mem_adaptor #(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pmem_read,
    input  logic              pmem_write,
    input  logic [ADDR_W-1:0] pmem_address,
    input  logic [LINE_W-1:0] pmem_wdata,
    output logic              pmem_resp,
    output logic [LINE_W-1:0] pmem_rdata,
    output logic              burst_read,
    output logic              burst_write,
    output logic [ADDR_W-1:0] burst_address,
    output logic [BEAT_W-1:0] burst_wdata,
    input  logic [BEAT_W-1:0] burst_rdata,
    input  logic              burst_resp
);

    import cache_pkg::*;

    localparam int BEATS = LINE_W / BEAT_W;
    localparam int CNT_W = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    adaptor_state_t r_state;
    adaptor_state_t w_next_state;

    logic [CNT_W-1:0]             r_beat_cnt;
    logic [ADDR_W-1:0]            r_addr;
    // Lines are held as beat arrays so the counter indexes a beat directly;
    // index 0 is bits 63:0 (little-endian beat order).
    logic [BEATS-1:0][BEAT_W-1:0] r_wline;
    logic [BEATS-1:0][BEAT_W-1:0] r_rdata;

    logic              w_in_burst;
    logic              w_last_beat;
    logic [ADDR_W-1:0] w_aligned_addr;

    assign w_in_burst     = (r_state == RD_BURST) || (r_state == WR_BURST);
    assign w_last_beat    = w_in_burst && burst_resp && (r_beat_cnt == LAST_BEAT);
    assign w_aligned_addr = {pmem_address[ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Write wins over read; a read still held by the cache is picked up from
    // IDLE after the write's DONE cycle.
    always_comb begin
        w_next_state = r_state;
        pmem_resp    = 1'b0;
        burst_read   = 1'b0;
        burst_write  = 1'b0;
        burst_wdata  = '0;
        case (r_state)
            IDLE: begin
                if (pmem_write) begin
                    w_next_state = WR_BURST;
                end else if (pmem_read) begin
                    w_next_state = RD_BURST;
                end
            end
            RD_BURST: begin
                burst_read = 1'b1;
                if (w_last_beat) begin
                    w_next_state = DONE;
                end
            end
            WR_BURST: begin
                burst_write = 1'b1;
                burst_wdata = r_wline[r_beat_cnt];
                if (w_last_beat) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                pmem_resp    = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Request fields are captured only in IDLE so later changes on the cache
    // side cannot disturb a burst in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_beat_cnt <= '0;
            r_addr     <= '0;
            r_wline    <= '0;
            r_rdata    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_beat_cnt <= '0;
                    if (pmem_write) begin
                        r_addr  <= w_aligned_addr;
                        r_wline <= pmem_wdata;
                    end else if (pmem_read) begin
                        r_addr <= w_aligned_addr;
                    end
                end
                RD_BURST: begin
                    if (burst_resp) begin
                        r_rdata[r_beat_cnt] <= burst_rdata;
                        r_beat_cnt          <= w_last_beat ? '0 : r_beat_cnt + 1'b1;
                    end
                end
                WR_BURST: begin
                    if (burst_resp) begin
                        r_beat_cnt <= w_last_beat ? '0 : r_beat_cnt + 1'b1;
                    end
                end
                default: begin
                    r_beat_cnt <= '0;
                end
            endcase
        end
    end

    assign pmem_rdata    = r_rdata;
    assign burst_address = r_addr;

endmodule

// File: tb/tb_cacheline_mem_adaptor.sv
// tb/tb_cacheline_mem_adaptor.sv - scoreboard bench for cacheline_mem_adaptor
module tb_cacheline_mem_adaptor;

    localparam int LW = 256;
    localparam int BW = 64;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pmem_read = 1'b0;
    logic          pmem_write = 1'b0;
    logic [AW-1:0] pmem_address = '0;
    logic [LW-1:0] pmem_wdata = '0;
    logic          pmem_resp;
    logic [LW-1:0] pmem_rdata;
    logic          burst_read;
    logic          burst_write;
    logic [AW-1:0] burst_address;
    logic [BW-1:0] burst_wdata;
    logic [BW-1:0] burst_rdata = '0;
    logic          burst_resp = 1'b0;

    int total = 0;
    int bad = 0;
    logic [LW-1:0] sb_q[$];

    always #5 clk = ~clk;

    cacheline_mem_adaptor dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pmem_read     (pmem_read),
        .pmem_write    (pmem_write),
        .pmem_address  (pmem_address),
        .pmem_wdata    (pmem_wdata),
        .pmem_resp     (pmem_resp),
        .pmem_rdata    (pmem_rdata),
        .burst_read    (burst_read),
        .burst_write   (burst_write),
        .burst_address (burst_address),
        .burst_wdata   (burst_wdata),
        .burst_rdata   (burst_rdata),
        .burst_resp    (burst_resp)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [LW-1:0] mk_line(input logic [3:0] d3, input logic [3:0] d2,
                                              input logic [3:0] d1, input logic [3:0] d0);
        return {{16{d3}}, {16{d2}}, {16{d1}}, {16{d0}}};
    endfunction

    task automatic wait_busy(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (burst_read || burst_write) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Memory model: returns n beats with `gap` idle cycles before each, captures
    // write beats at the moment they are acknowledged, counts bursting cycles.
    task automatic serve_beats(input logic [LW-1:0] line, input int first, input int n,
                               input int gap, inout logic [LW-1:0] wcap, inout int active);
        for (int b = first; b < first + n; b++) begin
            for (int g = 0; g < gap; g++) begin
                if (burst_read || burst_write) active++;
                @(negedge clk);
            end
            if (burst_read || burst_write) active++;
            wcap[b*BW +: BW] = burst_wdata;
            burst_rdata = line[b*BW +: BW];
            burst_resp  = 1'b1;
            @(negedge clk);
            burst_resp  = 1'b0;
            burst_rdata = '0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (pmem_resp !== 1'b0) begin bad++; $display("FAIL rst_resp: got %0b want 0", pmem_resp); end
        total++; if (burst_read !== 1'b0) begin bad++; $display("FAIL rst_bread: got %0b want 0", burst_read); end
        total++; if (burst_write !== 1'b0) begin bad++; $display("FAIL rst_bwrite: got %0b want 0", burst_write); end
        total++; if (burst_address !== '0) begin bad++; $display("FAIL rst_addr: got %0h want 0", burst_address); end
        total++; if (burst_wdata !== '0) begin bad++; $display("FAIL rst_wdata: got %0h want 0", burst_wdata); end
        total++; if (pmem_rdata !== '0) begin bad++; $display("FAIL rst_rdata: got %0h want 0", pmem_rdata); end
        rst_n = 1'b1;
        @(negedge clk);
        burst_rdata = {BW{1'b1}};
        burst_resp  = 1'b1;
        @(negedge clk);
        burst_resp  = 1'b0;
        burst_rdata = '0;
        @(negedge clk);
        total++; if (burst_read !== 1'b0 || burst_write !== 1'b0 || pmem_resp !== 1'b0) begin
            bad++; $display("FAIL idle_resp_ignored: got rd=%0b wr=%0b resp=%0b want 0 0 0", burst_read, burst_write, pmem_resp);
        end
        total++; if (pmem_rdata !== '0) begin bad++; $display("FAIL idle_rdata: got %0h want 0", pmem_rdata); end
    endtask

    task automatic test_read();
        logic [LW-1:0] line, wcap, exp;
        int active;
        bit ok;
        line = mk_line(4'h4, 4'h3, 4'h2, 4'h1);
        wcap = '0;
        active = 0;
        pmem_address = 32'h0000_1234;
        pmem_read = 1'b1;
        sb_q.push_back(line);
        wait_busy(ok);
        total++; if (!ok) begin bad++; $display("FAIL rd_start: got idle want burst"); end
        total++; if (burst_read !== 1'b1 || burst_write !== 1'b0) begin
            bad++; $display("FAIL rd_dir: got rd=%0b wr=%0b want 1 0", burst_read, burst_write);
        end
        total++; if (burst_address !== 32'h0000_1220) begin bad++; $display("FAIL rd_addr: got %0h want 1220", burst_address); end
        serve_beats(line, 0, 4, 0, wcap, active);
        total++; if (pmem_resp !== 1'b1) begin bad++; $display("FAIL rd_resp: got %0b want 1", pmem_resp); end
        if (pmem_resp === 1'b1 && sb_q.size() > 0) begin
            exp = sb_q.pop_front();
            total++; if (pmem_rdata !== exp) begin bad++; $display("FAIL rd_line: got %0h want %0h", pmem_rdata, exp); end
        end
        pmem_read = 1'b0;
        @(negedge clk);
        total++; if (pmem_resp !== 1'b0 || burst_read !== 1'b0) begin
            bad++; $display("FAIL rd_resp_once: got resp=%0b rd=%0b want 0 0", pmem_resp, burst_read);
        end
    endtask

    task automatic test_write();
        logic [LW-1:0] line, wcap, prev_rdata;
        int active;
        bit ok;
        line = mk_line(4'hD, 4'hC, 4'hB, 4'hA);
        wcap = '0;
        active = 0;
        prev_rdata = mk_line(4'h4, 4'h3, 4'h2, 4'h1);
        pmem_address = 32'h0000_2040;
        pmem_wdata = line;
        pmem_write = 1'b1;
        wait_busy(ok);
        total++; if (!ok || burst_write !== 1'b1 || burst_read !== 1'b0) begin
            bad++; $display("FAIL wr_dir: got rd=%0b wr=%0b want 0 1", burst_read, burst_write);
        end
        pmem_address = 32'hFFFF_FFFF;
        pmem_wdata = '1;
        total++; if (burst_address !== 32'h0000_2040) begin bad++; $display("FAIL wr_addr: got %0h want 2040", burst_address); end
        serve_beats(line, 0, 4, 2, wcap, active);
        total++; if (wcap !== line) begin bad++; $display("FAIL wr_beats: got %0h want %0h", wcap, line); end
        total++; if (active !== 12) begin bad++; $display("FAIL wr_active: got %0d want 12", active); end
        total++; if (pmem_resp !== 1'b1) begin bad++; $display("FAIL wr_resp: got %0b want 1", pmem_resp); end
        total++; if (pmem_rdata !== prev_rdata) begin bad++; $display("FAIL wr_rdata_kept: got %0h want %0h", pmem_rdata, prev_rdata); end
        pmem_write = 1'b0;
        @(negedge clk);
        total++; if (pmem_resp !== 1'b0 || burst_write !== 1'b0) begin
            bad++; $display("FAIL wr_resp_once: got resp=%0b wr=%0b want 0 0", pmem_resp, burst_write);
        end
    endtask

    task automatic test_priority();
        logic [LW-1:0] wline, rline, wcap, exp;
        int active;
        bit ok;
        wline = mk_line(4'h9, 4'h8, 4'h7, 4'h6);
        rline = mk_line(4'h5, 4'hE, 4'hF, 4'h0);
        wcap = '0;
        active = 0;
        pmem_address = 32'h0000_3000;
        pmem_wdata = wline;
        pmem_write = 1'b1;
        pmem_read = 1'b1;
        sb_q.push_back(rline);
        wait_busy(ok);
        total++; if (!ok || burst_write !== 1'b1 || burst_read !== 1'b0) begin
            bad++; $display("FAIL pri_write_first: got rd=%0b wr=%0b want 0 1", burst_read, burst_write);
        end
        serve_beats(wline, 0, 4, 0, wcap, active);
        total++; if (wcap !== wline || pmem_resp !== 1'b1) begin
            bad++; $display("FAIL pri_write_done: got resp=%0b beats=%0h want 1 %0h", pmem_resp, wcap, wline);
        end
        pmem_write = 1'b0;
        @(negedge clk);
        total++; if (pmem_resp !== 1'b0) begin bad++; $display("FAIL pri_gap: got %0b want 0", pmem_resp); end
        wait_busy(ok);
        total++; if (!ok || burst_read !== 1'b1) begin bad++; $display("FAIL pri_read_next: got rd=%0b want 1", burst_read); end
        serve_beats(rline, 0, 4, 1, wcap, active);
        total++; if (pmem_resp !== 1'b1) begin bad++; $display("FAIL pri_read_resp: got %0b want 1", pmem_resp); end
        if (pmem_resp === 1'b1 && sb_q.size() > 0) begin
            exp = sb_q.pop_front();
            total++; if (pmem_rdata !== exp) begin bad++; $display("FAIL pri_read_line: got %0h want %0h", pmem_rdata, exp); end
        end
        pmem_read = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_burst();
        logic [LW-1:0] xline, yline, wcap, exp;
        int active, pulses;
        bit ok;
        xline = mk_line(4'h1, 4'h2, 4'h3, 4'h4);
        yline = mk_line(4'hA, 4'h5, 4'hA, 4'h5);
        wcap = '0;
        active = 0;
        pulses = 0;
        pmem_address = 32'h0000_4000;
        pmem_read = 1'b1;
        wait_busy(ok);
        serve_beats(xline, 0, 2, 0, wcap, active);
        rst_n = 1'b0;
        pmem_read = 1'b0;
        @(negedge clk);
        total++; if (burst_read !== 1'b0 || pmem_resp !== 1'b0) begin
            bad++; $display("FAIL mid_rst_abort: got rd=%0b resp=%0b want 0 0", burst_read, pmem_resp);
        end
        total++; if (pmem_rdata !== '0) begin bad++; $display("FAIL mid_rst_rdata: got %0h want 0", pmem_rdata); end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (pmem_resp === 1'b1) pulses++;
        end
        total++; if (pulses !== 0) begin bad++; $display("FAIL mid_rst_no_resp: got %0d want 0", pulses); end
        pmem_address = 32'h0000_4020;
        pmem_read = 1'b1;
        sb_q.push_back(yline);
        wait_busy(ok);
        total++; if (!ok || burst_address !== 32'h0000_4020) begin
            bad++; $display("FAIL mid_rst_fresh_addr: got %0h want 4020", burst_address);
        end
        serve_beats(yline, 0, 4, 0, wcap, active);
        total++; if (pmem_resp !== 1'b1) begin bad++; $display("FAIL mid_rst_fresh_resp: got %0b want 1", pmem_resp); end
        if (pmem_resp === 1'b1 && sb_q.size() > 0) begin
            exp = sb_q.pop_front();
            total++; if (pmem_rdata !== exp) begin bad++; $display("FAIL mid_rst_fresh_line: got %0h want %0h", pmem_rdata, exp); end
        end
        pmem_read = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_drop_mid_burst();
        logic [LW-1:0] zline, wcap, exp;
        int active, pulses;
        bit ok;
        zline = mk_line(4'h7, 4'hB, 4'hC, 4'h3);
        wcap = '0;
        active = 0;
        pulses = 0;
        pmem_address = 32'h0000_5008;
        pmem_read = 1'b1;
        sb_q.push_back(zline);
        wait_busy(ok);
        serve_beats(zline, 0, 1, 0, wcap, active);
        pmem_read = 1'b0;
        serve_beats(zline, 1, 3, 0, wcap, active);
        total++; if (active !== 4) begin bad++; $display("FAIL drop_active: got %0d want 4", active); end
        total++; if (pmem_resp !== 1'b1) begin bad++; $display("FAIL drop_resp: got %0b want 1", pmem_resp); end
        if (pmem_resp === 1'b1 && sb_q.size() > 0) begin
            exp = sb_q.pop_front();
            total++; if (pmem_rdata !== exp) begin bad++; $display("FAIL drop_line: got %0h want %0h", pmem_rdata, exp); end
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (pmem_resp === 1'b1 || burst_read === 1'b1) pulses++;
        end
        total++; if (pulses !== 0) begin bad++; $display("FAIL drop_retrigger: got %0d want 0", pulses); end
    endtask

    task automatic test_back_to_back();
        logic [LW-1:0] aline, bline, wcap, exp, mixed;
        int active;
        bit ok;
        aline = mk_line(4'h1, 4'h0, 4'hF, 4'hE);
        bline = mk_line(4'h6, 4'h9, 4'h6, 4'h9);
        wcap = '0;
        active = 0;
        pmem_address = 32'h0000_0100;
        pmem_read = 1'b1;
        sb_q.push_back(aline);
        wait_busy(ok);
        total++; if (!ok || burst_address !== 32'h0000_0100) begin
            bad++; $display("FAIL b2b_addr0: got %0h want 100", burst_address);
        end
        serve_beats(aline, 0, 4, 0, wcap, active);
        if (pmem_resp === 1'b1 && sb_q.size() > 0) begin
            exp = sb_q.pop_front();
            total++; if (pmem_rdata !== exp) begin bad++; $display("FAIL b2b_line0: got %0h want %0h", pmem_rdata, exp); end
        end else begin
            total++; bad++; $display("FAIL b2b_resp0: got %0b want 1", pmem_resp);
        end
        pmem_read = 1'b0;
        @(negedge clk);
        pmem_address = 32'h0000_0120;
        pmem_read = 1'b1;
        sb_q.push_back(bline);
        wait_busy(ok);
        total++; if (!ok || burst_address !== 32'h0000_0120) begin
            bad++; $display("FAIL b2b_addr1: got %0h want 120", burst_address);
        end
        total++; if (pmem_rdata !== aline) begin bad++; $display("FAIL b2b_hold: got %0h want %0h", pmem_rdata, aline); end
        serve_beats(bline, 0, 1, 1, wcap, active);
        mixed = {aline[LW-1:BW], bline[BW-1:0]};
        total++; if (pmem_rdata !== mixed) begin bad++; $display("FAIL b2b_first_beat: got %0h want %0h", pmem_rdata, mixed); end
        serve_beats(bline, 1, 3, 0, wcap, active);
        total++; if (pmem_resp !== 1'b1) begin bad++; $display("FAIL b2b_resp1: got %0b want 1", pmem_resp); end
        if (pmem_resp === 1'b1 && sb_q.size() > 0) begin
            exp = sb_q.pop_front();
            total++; if (pmem_rdata !== exp) begin bad++; $display("FAIL b2b_line1: got %0h want %0h", pmem_rdata, exp); end
        end
        pmem_read = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_priority();
        test_reset_mid_burst();
        test_drop_mid_burst();
        test_back_to_back();
        total++; if (sb_q.size() !== 0) begin bad++; $display("FAIL sb_drain: got %0d want 0", sb_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cacheline_mem_adaptor.md
Name: cacheline_mem_adaptor

Overview:
- Responder on the cache-side physical-memory port: pmem_read, pmem_write, pmem_address, 256-bit pmem_wdata/pmem_rdata and pmem_resp, as driven by icache and dcache.
- Converts each 256-bit line request into a 4-beat, 64-bit burst on the physical memory bus.
- Returns the assembled line with a one-cycle response pulse.
- Sits between the cache (or the L1 arbiter output) and main memory.

Parameters:
- LINE_W, 256, line width in bits
- BEAT_W, 64, burst beat width in bits
- ADDR_W, 32, address width
- BEATS (derived, LINE_W/BEAT_W = 4), beats per line; not overridable

Ports:
- clk  in  1  clock; all logic rising-edge
- rst_n  in  1  synchronous active-low reset, sampled on rising clk
- pmem_read  in  1  cache line-read request; held until pmem_resp
- pmem_write  in  1  cache line-write request; held until pmem_resp
- pmem_address  in  ADDR_W  line address from cache
- pmem_wdata  in  LINE_W  line write data
- pmem_resp  out  1  one-cycle completion pulse to cache
- pmem_rdata  out  LINE_W  assembled read line
- burst_read  out  1  memory burst read request
- burst_write  out  1  memory burst write request
- burst_address  out  ADDR_W  line-aligned burst address
- burst_wdata  out  BEAT_W  current write beat
- burst_rdata  in  BEAT_W  read beat, valid when burst_resp=1
- burst_resp  in  1  per-beat handshake from memory

Behaviour:
- Reset (rst_n=0 at a rising edge): state=IDLE, beat_cnt=0; pmem_resp=0, burst_read=0, burst_write=0, burst_address=0, burst_wdata=0, pmem_rdata=0.
  - Reset asserted mid-burst aborts immediately to IDLE; the partial line is discarded.
- States: IDLE, RD_BURST, WR_BURST, DONE.
- IDLE:
  - pmem_write=1 -> latch {pmem_address[ADDR_W-1:5],5'b0} and pmem_wdata; go to WR_BURST.
  - Otherwise pmem_read=1 -> latch aligned address; go to RD_BURST.
  - Write has priority when both are asserted. The read is served after the write completes, if the cache still holds it.
- RD_BURST:
  - burst_read=1, burst_address=latched address.
  - Each cycle with burst_resp=1: store burst_rdata into line slice [beat_cnt*64 +: 64], then beat_cnt++.
  - Beats are little-endian: beat 0 is bits 63:0.
  - Gaps between resp beats are allowed.
  - When the 4th beat is accepted (beat_cnt==3 && burst_resp): go to DONE, beat_cnt=0.
- WR_BURST:
  - burst_write=1; burst_wdata = latched line slice [beat_cnt].
  - Each burst_resp=1 advances beat_cnt.
  - 4th resp -> DONE.
- DONE:
  - pmem_resp=1 for exactly one cycle; burst_read and burst_write are 0.
  - Next state is IDLE unconditionally. The cache drops its request in the cycle after resp, so no re-trigger occurs.
- pmem_rdata is registered and updates only on accepted read beats. It stays stable from DONE until the next read's first beat.
- burst_read/burst_write are driven combinationally from state and are never asserted together.
- Latency:
  - Request seen in IDLE at edge N -> burst_* asserted in cycle N+1.
  - pmem_resp is asserted in the cycle after the 4th burst_resp.
  - Minimum total (zero memory latency, contiguous beats) = 6 cycles from request to resp.
- Request deasserted mid-burst: the burst completes (memory cannot abort) and pmem_resp still pulses.
- pmem_address/pmem_wdata changes after IDLE acceptance are ignored; the latched copies are used.
- burst_resp while in IDLE or DONE is ignored.
- beat_cnt is 2 bits and wraps naturally; it is cleared on entry to DONE.

Decomposition:
- Shared package cache_pkg:
  - state enum adaptor_state_t {IDLE, RD_BURST, WR_BURST, DONE}
  - LINE_W/BEAT_W/ADDR_W constants
  - OFFSET_BITS=5 alignment constant
- No sub-module; single FSM plus 256-bit line register and 2-bit counter.

Test Plan:
- Read pmem_address=0x0000_1234; memory returns beats 0x1111..., 0x2222..., 0x3333..., 0x4444... contiguously -> burst_address=0x0000_1220; pmem_rdata={4444..,3333..,2222..,1111..}; pmem_resp high exactly 1 cycle after the 4th burst_resp.
- Write 0x0000_2040, line=0xDDDD..CCCC..BBBB..AAAA.. (MSB→LSB), memory resp with 2-cycle gaps -> burst_wdata sequence AAAA.., BBBB.., CCCC.., DDDD.., each advancing only on resp; single pmem_resp.
- pmem_read and pmem_write both high in IDLE -> WR_BURST first; after resp, the held read runs a full RD_BURST.
- rst_n=0 after 2 read beats -> next cycle IDLE, burst_read=0, pmem_resp never pulses; a fresh read then completes normally.
- pmem_read dropped after 1 beat -> burst_read stays high for the remaining 3 beats; pmem_resp pulses once.
- Back-to-back reads 0x100 then 0x120 -> pmem_rdata holds the first line until the second read's first beat; burst_address=0x100 then 0x120.
